// File: rtl/exprnd_pipe_if.sv
// exprnd_pipe_if: handshake and data bundle for the exponent-rounding stage.
// master = upstream/downstream environment, slave = exprnd_pipe.
interface exprnd_pipe_if #(
   parameter int EW = 11,
   parameter int FW = 52
);
   logic          in_valid;
   logic          in_ready;
   logic          s;
   logic [EW-1:0] e3;
   logic [FW:0]   f3;
   logic [1:0]    RM;
   logic          OVF;
   logic          UNF;
   logic          OVFen;
   logic          UNFen;
   logic          INX;
   logic          out_valid;
   logic          out_ready;
   logic          s_out;
   logic [EW-1:0] eout;
   logic [FW-1:0] fout;
   logic [2:0]    flags;
   logic          flag_clr;
   logic [2:0]    sticky;

   modport master (
      output in_valid, s, e3, f3, RM, OVF, UNF, OVFen, UNFen, INX, out_ready, flag_clr,
      input  in_ready, out_valid, s_out, eout, fout, flags, sticky
   );

   modport slave (
      input  in_valid, s, e3, f3, RM, OVF, UNF, OVFen, UNFen, INX, out_ready, flag_clr,
      output in_ready, out_valid, s_out, eout, fout, flags, sticky
   );
endinterface

// File: rtl/exprnd_pipe.sv
// exprnd_pipe: two-stage valid/ready exponent-rounding / special-value stage.
// Resolves masked overflow (infinity or Xmax by rounding mode), masked
// underflow (signed zero), denormal exponent zeroing, and packs the result
// with per-beat {ovf, unf, inx} flags.
// Optional: define EXPRND_PIPE_STICKY_EN for accumulated sticky flags.
module exprnd_pipe #(
   parameter int EW = 11,
   parameter int FW = 52
) (
   input logic          clk,
   input logic          rst_n,
   exprnd_pipe_if.slave bus
);

   typedef enum logic [1:0] {SEL_PASS, SEL_INF, SEL_XMAX, SEL_ZERO} sel_t;

   logic          adv1, adv2;
   logic          v1, v2;
   logic          inf_sel;
   sel_t          sel_c;
   logic          inx_c;

   logic          s1;
   logic [EW-1:0] e1;
   logic [FW:0]   f1;
   sel_t          sel1;
   logic [2:0]    flg1;

   logic          s2;
   logic [EW-1:0] e2;
   logic [FW-1:0] f2;
   logic [2:0]    flg2;

   logic [EW-1:0] e_pk;
   logic [FW-1:0] f_pk;

   assign adv2         = ~v2 | bus.out_ready;
   assign adv1         = ~v1 | adv2;
   assign bus.in_ready = adv1;

   // Decide which special-value path the incoming beat takes
   always_comb begin
      inf_sel = bus.RM[1] ? bus.RM[0] : ~(bus.RM[0] ^ bus.s);
      sel_c   = SEL_PASS;
      if (bus.OVF && !bus.OVFen)
         sel_c = inf_sel ? SEL_INF : SEL_XMAX;
      else if (bus.UNF && !bus.UNFen && !bus.OVF)
         sel_c = SEL_ZERO;
      inx_c = bus.INX | (bus.OVF & ~bus.OVFen) | (bus.UNF & ~bus.UNFen & ~bus.OVF);
   end

   // Stage 1: capture inputs, resolved selection and flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         s1   <= 1'b0;
         e1   <= '0;
         f1   <= '0;
         sel1 <= SEL_PASS;
         flg1 <= '0;
      end else if (adv1) begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            s1   <= bus.s;
            e1   <= bus.e3;
            f1   <= bus.f3;
            sel1 <= sel_c;
            flg1 <= {bus.OVF, bus.UNF, inx_c};
         end
      end
   end

   // Pack exponent/fraction from the stage-1 selection
   always_comb begin
      e_pk = e1 & {EW{f1[FW]}};
      f_pk = f1[FW-1:0];
      case (sel1)
         SEL_INF: begin
            e_pk = '1;
            f_pk = '0;
         end
         SEL_XMAX: begin
            e_pk = {{(EW-1){1'b1}}, 1'b0};
            f_pk = '1;
         end
         SEL_ZERO: begin
            e_pk = '0;
            f_pk = '0;
         end
         default: ;
      endcase
   end

   // Stage 2: register packed result and flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2   <= 1'b0;
         s2   <= 1'b0;
         e2   <= '0;
         f2   <= '0;
         flg2 <= '0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            s2   <= s1;
            e2   <= e_pk;
            f2   <= f_pk;
            flg2 <= flg1;
         end
      end
   end

   assign bus.out_valid = v2;
   assign bus.s_out     = s2;
   assign bus.eout      = e2;
   assign bus.fout      = f2;
   assign bus.flags     = flg2;

`ifdef EXPRND_PIPE_STICKY_EN
   logic [2:0] sticky_q;

   // Accumulate flags of transferred beats; a same-cycle set overrides clear
   always_ff @(posedge clk) begin
      if (!rst_n)
         sticky_q <= '0;
      else
         sticky_q <= (bus.flag_clr ? 3'b000 : sticky_q) |
                     ((v2 && bus.out_ready) ? flg2 : 3'b000);
   end

   assign bus.sticky = sticky_q;
`else
   logic unused_flag_clr;

   assign unused_flag_clr = bus.flag_clr;
   assign bus.sticky      = '0;
`endif

endmodule

// File: tb/tb_exprnd_pipe.sv
// tb_exprnd_pipe: scoreboard bench for exprnd_pipe (EW=11, FW=52).
module tb_exprnd_pipe;
   localparam int EW = 11;
   localparam int FW = 52;

   typedef struct packed {
      logic          s;
      logic [EW-1:0] e3;
      logic [FW:0]   f3;
      logic [1:0]    rm;
      logic          ovf;
      logic          unf;
      logic          ovfen;
      logic          unfen;
      logic          inx;
   } beat_t;

   typedef struct packed {
      logic          s;
      logic [EW-1:0] e;
      logic [FW-1:0] f;
      logic [2:0]    fl;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;

   exprnd_pipe_if #(.EW(EW), .FW(FW)) bus ();
   exprnd_pipe #(.EW(EW), .FW(FW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   res_t       expq[$];
   int         rdy_mode = 0;   // 0 ready, 1 random, 2 stalled
   int         accepted = 0;
   logic [2:0] exp_sticky = 3'b000;
   bit         stall_prev = 0;
   res_t       held;

   task automatic chk(string name, logic [127:0] act, logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference: result of one beat from the operation rules
   function automatic res_t model(beat_t b);
      res_t          r;
      bit            to_inf;
      logic [EW-1:0] emax;
      emax = '1;
      case (b.rm)
         2'b00:   to_inf = (b.s == 1'b0);
         2'b01:   to_inf = (b.s == 1'b1);
         2'b10:   to_inf = 1'b0;
         default: to_inf = 1'b1;
      endcase
      r.s  = b.s;
      r.fl = {b.ovf, b.unf, b.inx};
      if (b.ovf && !b.ovfen) begin
         r.fl[0] = 1'b1;
         if (to_inf) begin
            r.e = emax;
            r.f = '0;
         end else begin
            r.e = emax - 1;
            r.f = '1;
         end
      end else if (b.unf && !b.unfen && !b.ovf) begin
         r.fl[0] = 1'b1;
         r.e = '0;
         r.f = '0;
      end else begin
         r.e = b.f3[FW] ? b.e3 : '0;
         r.f = b.f3[FW-1:0];
      end
      return r;
   endfunction

   function automatic beat_t mk(logic s, logic [EW-1:0] e3, logic [FW:0] f3, logic [1:0] rm,
                                logic ovf, logic unf, logic ovfen, logic unfen, logic inx);
      beat_t b;
      b = {s, e3, f3, rm, ovf, unf, ovfen, unfen, inx};
      return b;
   endfunction

   function automatic beat_t rnd_beat();
      beat_t b;
      b.s     = 1'($urandom_range(0, 1));
      b.e3    = EW'($urandom());
      b.f3    = (FW+1)'({$urandom(), $urandom()});
      b.f3[FW] = ($urandom_range(0, 3) != 0);
      b.rm    = 2'($urandom());
      b.ovf   = ($urandom_range(0, 3) == 0);
      b.unf   = ($urandom_range(0, 3) == 0);
      b.ovfen = ($urandom_range(0, 2) == 0);
      b.unfen = ($urandom_range(0, 2) == 0);
      b.inx   = 1'($urandom_range(0, 1));
      return b;
   endfunction

   // Downstream ready generator
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = ($urandom_range(0, 3) != 0);
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Monitor/scoreboard: sampled mid-cycle, transfers complete at next edge
   always @(negedge clk) begin
      res_t       act;
      res_t       e;
      beat_t      cur;
      logic [2:0] nxt;
      if (!rst_n) begin
         expq.delete();
         exp_sticky = 3'b000;
         stall_prev = 0;
      end else begin
         act = {bus.s_out, bus.eout, bus.fout, bus.flags};
         chk("sticky", 128'(bus.sticky), 128'(exp_sticky));
         if (stall_prev) begin
            chk("hold_valid", 128'(bus.out_valid), 128'(1));
            chk("hold_data", 128'(act), 128'(held));
         end
         nxt = bus.flag_clr ? 3'b000 : exp_sticky;
         if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got %0h, expected no beat", act);
            end else begin
               e = expq.pop_front();
               chk("out_beat", 128'(act), 128'(e));
               nxt = nxt | e.fl;
            end
         end
`ifdef EXPRND_PIPE_STICKY_EN
         exp_sticky = nxt;
`endif
         stall_prev = bus.out_valid && !bus.out_ready;
         held       = act;
         if (bus.in_valid && bus.in_ready) begin
            cur = {bus.s, bus.e3, bus.f3, bus.RM, bus.OVF, bus.UNF, bus.OVFen, bus.UNFen, bus.INX};
            expq.push_back(model(cur));
            accepted++;
         end
      end
   end

   task automatic send(beat_t b);
      int n = 0;
      bit done = 0;
      bus.s        = b.s;
      bus.e3       = b.e3;
      bus.f3       = b.f3;
      bus.RM       = b.rm;
      bus.OVF      = b.ovf;
      bus.UNF      = b.unf;
      bus.OVFen    = b.ovfen;
      bus.UNFen    = b.unfen;
      bus.INX      = b.inx;
      bus.in_valid = 1'b1;
      while (!done && n < 200) begin
         @(negedge clk);
         done = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no in_ready, expected accept within 200 cycles");
      end
   endtask

   task automatic idle(int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 0;
      while (expq.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending beats, expected 0", expq.size());
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.s        = 1'b0;
      bus.e3       = '0;
      bus.f3       = '0;
      bus.RM       = 2'b00;
      bus.OVF      = 1'b0;
      bus.UNF      = 1'b0;
      bus.OVFen    = 1'b0;
      bus.UNFen    = 1'b0;
      bus.INX      = 1'b0;
      bus.flag_clr = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_s_out", 128'(bus.s_out), 128'(0));
      chk("rst_eout", 128'(bus.eout), 128'(0));
      chk("rst_fout", 128'(bus.fout), 128'(0));
      chk("rst_flags", 128'(bus.flags), 128'(0));
      chk("rst_sticky", 128'(bus.sticky), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
      @(posedge clk);
      #1;

      // Directed beats from the operation rules
      send(mk(1'b0, 11'h400, {1'b1, 52'h8_0000_0000_0000}, 2'b00, 0, 0, 0, 0, 0));
      send(mk(1'b0, 11'h123, 53'h1F_FFFF_FFFF_FFFF, 2'b00, 1, 0, 0, 0, 0));
      send(mk(1'b1, 11'h123, 53'h1F_FFFF_FFFF_FFFF, 2'b00, 1, 0, 0, 0, 0));
      send(mk(1'b0, 11'h001, {1'b0, 52'h3}, 2'b00, 0, 0, 0, 0, 0));
      send(mk(1'b1, 11'h001, {1'b0, 52'h5}, 2'b00, 0, 1, 0, 0, 0));
      send(mk(1'b0, 11'h7FE, {1'b1, 52'h1}, 2'b01, 1, 0, 1, 0, 0));
      send(mk(1'b1, 11'h7FE, {1'b1, 52'h2}, 2'b01, 1, 1, 0, 0, 1));
      send(mk(1'b0, 11'h055, {1'b1, 52'h3}, 2'b10, 1, 0, 0, 0, 0));
      send(mk(1'b1, 11'h055, {1'b1, 52'h4}, 2'b11, 1, 0, 0, 0, 0));
      send(mk(1'b0, 11'h002, {1'b1, 52'h9}, 2'b00, 1, 1, 1, 0, 0));
      send(mk(1'b0, 11'h003, {1'b1, 52'h7}, 2'b00, 0, 1, 0, 1, 1));
      drain();

      // Backpressure: 5 beats against a stalled output
      rdy_mode = 2;
      idle(2);
      base = accepted;
      fork
         begin
            for (int i = 0; i < 5; i++) send(rnd_beat());
         end
         begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("bp_accepted", 128'(accepted - base), 128'(2));
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
            chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
            rdy_mode = 0;
         end
      join
      drain();
      chk("bp_total", 128'(accepted - base), 128'(5));

      // Reset with both stages full
      rdy_mode = 2;
      idle(2);
      send(rnd_beat());
      send(rnd_beat());
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
      rdy_mode = 0;
      @(posedge clk);
      #1;
      idle(5);
      chk("midrst_no_output", 128'(bus.out_valid), 128'(0));

      // Sticky: clear coinciding with a setting transfer, then clear alone
      bus.flag_clr = 1'b1;
      send(mk(1'b0, 11'h010, {1'b1, 52'h1}, 2'b00, 1, 0, 0, 0, 0));
      idle(4);
      bus.flag_clr = 1'b0;
      send(mk(1'b1, 11'h011, {1'b1, 52'h2}, 2'b00, 0, 1, 0, 0, 1));
      drain();
      idle(2);

      // Randomized traffic with random backpressure and clears
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         bus.flag_clr = ($urandom_range(0, 7) == 0);
         send(rnd_beat());
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      bus.flag_clr = 1'b0;
      drain();
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
